// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause codes,
// and a small helper for sizing counters.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      REL  = 2'd1,
      RUN  = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_GLB = 2'b00;
   localparam logic [1:0] CAUSE_CLK = 2'b01;
   localparam logic [1:0] CAUSE_BTN = 2'b10;
   localparam logic [1:0] CAUSE_SW  = 2'b11;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Trigger inputs and reset outputs of the sequencer. The slave side is the sequencer.
// The master side is whatever drives the triggers.
interface rst_seq_if #(
   parameter int NCH = 3
);
   logic           clk_ok;
   logic           btn_n;
   logic           sw_rst_req;
   logic [NCH-1:0] rst;
   logic           rst_done;
   logic [1:0]     rst_cause;

   modport master (
      output clk_ok, btn_n, sw_rst_req,
      input  rst, rst_done, rst_cause
   );

   modport slave (
      input  clk_ok, btn_n, sw_rst_req,
      output rst, rst_done, rst_cause
   );
endinterface

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer. Synchronous active-low reset loads both flops with RST_VAL,
// so the output shows an idle level while the block is in reset.
module rst_seq_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds NCH resets after any trigger, then releases them in index order.
// Channels release GAP_CYC cycles apart. The cause of the last reset is latched.
//
// state | meaning
// HOLD  | all channels asserted, counting HOLD_CYC trigger-free cycles
// REL   | releasing channels one by one, GAP_CYC cycles apart
// RUN   | all channels released, waiting for a trigger
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int NCH      = 3,
   parameter int HOLD_CYC = 16,
   parameter int GAP_CYC  = 4,
   parameter int DEB_CYC  = 8
) (
   input  logic         clk_in,
   input  logic         rst_in_n,
   rst_seq_if.slave     bus
);
   localparam int CW = $clog2(max2(HOLD_CYC, GAP_CYC)) + 1;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW = $clog2(DEB_CYC + 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [NCH-1:0] rst_q, rst_d;
   logic           done_q, done_d;
   logic [1:0]     cause_q, cause_d;
   logic [DW-1:0]  deb_q, deb_d;
   logic           btn_sync;
   logic           btn_act;
   logic           trig;

   rst_seq_sync2 #(.RST_VAL(1'b1)) u_btn_sync (
      .clk_i  (clk_in),
      .rst_ni (rst_in_n),
      .d_i    (bus.btn_n),
      .q_o    (btn_sync)
   );

   // Debounce saturates so a held button keeps btn_act asserted without wrapping.
   always_comb begin
      deb_d = deb_q;
      if (btn_sync)
         deb_d = '0;
      else if (deb_q != DW'(DEB_CYC))
         deb_d = deb_q + 1'b1;
   end

   assign btn_act = (deb_q == DW'(DEB_CYC));
   assign trig    = !bus.clk_ok || btn_act || bus.sw_rst_req;

   always_ff @(posedge clk_in) begin
      if (!rst_in_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         cause_q <= CAUSE_GLB;
         deb_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         cause_q <= cause_d;
         deb_q   <= deb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      done_d  = done_q;
      cause_d = cause_q;
      if (trig) begin
         state_d = HOLD;
         cnt_d   = '0;
         rst_d   = '1;
         done_d  = 1'b0;
         if (!bus.clk_ok)
            cause_d = CAUSE_CLK;
         else if (btn_act)
            cause_d = CAUSE_BTN;
         else
            cause_d = CAUSE_SW;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (cnt_q == CW'(HOLD_CYC - 1)) begin
                  rst_d[0] = 1'b0;
                  cnt_d    = '0;
                  idx_d    = IW'(1);
                  if (NCH == 1) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = REL;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            REL: begin
               if (cnt_q == CW'(GAP_CYC - 1)) begin
                  rst_d[idx_q] = 1'b0;
                  cnt_d        = '0;
                  if (idx_q == IW'(NCH - 1)) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RUN: ;
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_d   = '1;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.rst       = rst_q;
      bus.rst_done  = done_q;
      bus.rst_cause = cause_q;
   end
endmodule
